token_buffer: RTL

TOKEN_BUFFER -- requirements
Module: token_buffer

---
 rtl/token_buffer.sv | 104 ++++++++++
 1 files changed

// File: rtl/token_buffer.sv
// Token queue between a lexer and a parser: circular FWFT FIFO with sticky overflow/EOF-done flags.
// Optional second-entry lookahead is enabled by defining TOKBUF_PEEK_EN.
module token_buffer #(
  parameter int         DEPTH  = 16,
  parameter logic [7:0] EOF_ID = 8'h01
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     I_VALID,
  input  logic [15:0]              I_DATA,
  output logic                     O_VALID,
  output logic [15:0]              O_DATA,
  input  logic                     O_READY,
  output logic                     O_PEEK_VALID,
  output logic [15:0]              O_PEEK_DATA,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  output logic                     DONE
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;
  logic          eof_seen_q, eof_seen_d;
  logic          full, pop, wr_req, wr_en;

  always_comb begin
    O_VALID    = (count_q != '0);
    O_DATA     = O_VALID ? mem_q[rd_ptr_q] : 16'h0000;
    full       = (count_q == FULL_CNT);
    pop        = O_VALID && O_READY;
    wr_req     = I_VALID && !eof_seen_q;
    // A full queue still takes a write when the head leaves in the same cycle.
    wr_en      = wr_req && (!full || pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    done_d     = done_q;
    eof_seen_d = eof_seen_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (I_DATA[15:8] == EOF_ID) eof_seen_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (O_DATA[15:8] == EOF_ID) done_d = 1'b1;
    end
    if (wr_req && full && !pop) overflow_d = 1'b1;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      eof_seen_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      eof_seen_q <= eof_seen_d;
    end
  end

  // Storage is never cleared; occupancy alone decides what is visible.
  always_ff @(posedge CLK) begin
    if (!RST && wr_en) mem_q[wr_ptr_q] <= I_DATA;
  end

`ifdef TOKBUF_PEEK_EN
  logic [AW-1:0] peek_ptr;
  always_comb begin
    peek_ptr     = rd_ptr_q + PTR_ONE;
    O_PEEK_VALID = (count_q >= (AW+1)'(2));
    O_PEEK_DATA  = O_PEEK_VALID ? mem_q[peek_ptr] : 16'h0000;
  end
`else
  assign O_PEEK_VALID = 1'b0;
  assign O_PEEK_DATA  = 16'h0000;
`endif

  assign COUNT    = count_q;
  assign OVERFLOW = overflow_q;
  assign DONE     = done_q;

endmodule
